// File: rtl/fft8_ctrl.sv
// fft8_ctrl
// Frame sequencer for a combinational 8-point FFT core.
// Collects eight real samples over a valid/ready input and holds them on
// core_a. It then waits SETTLE cycles for the core's long combinational path
// and captures all sixteen result words in one cycle. Finally it streams the
// eight complex bins out in natural order over a valid/ready output.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   s_valid/s_ready/s_data  sample input handshake, s_last ends a frame
//   core_a                  held frame, sample i at [DATA_W*i +: DATA_W]
//   core_xr/core_xi         core results, bin k at [DATA_W*k +: DATA_W]
//   m_valid/m_ready         bin output handshake
//   m_re/m_im/m_idx/m_last  bin value, index and last-bin flag
//   busy                    block is mid-frame
//   err/err_clr             sticky framing error and its synchronous clear
//   frame_cnt               completed frame counter, wraps at 16 bits

module fft8_ctrl #(
  parameter int DATA_W = 32,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic [8*DATA_W-1:0]   core_a,
  input  logic [8*DATA_W-1:0]   core_xr,
  input  logic [8*DATA_W-1:0]   core_xi,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_re,
  output logic [DATA_W-1:0]     m_im,
  output logic [2:0]            m_idx,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t                   state_q;
  logic [2:0]               cnt_q;
  logic [3:0]               settle_q;
  logic [2:0]               k_q;
  logic [7:0][DATA_W-1:0]   samp_q;
  logic [7:0][DATA_W-1:0]   resRe_q;
  logic [7:0][DATA_W-1:0]   resIm_q;
  logic                     err_q;
  logic                     err_d;
  logic [15:0]              frameCnt_q;

  logic accept;
  logic fire;
  logic errSet;

  assign accept = (state_q == ST_LOAD) && s_valid;
  assign fire   = (state_q == ST_DRAIN) && m_ready;

  // Framing errors occur in two cases. One is s_last arriving before the
  // eighth sample. The other is the eighth sample arriving without s_last.
  assign errSet = accept && ((s_last && (cnt_q != 3'd7)) ||
                             (!s_last && (cnt_q == 3'd7)));

  // A new error event wins over a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (errSet)  err_d = 1'b1;
  end

  // Main sequencer: sample loading, settle wait, result capture and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      settle_q   <= '0;
      k_q        <= '0;
      samp_q     <= '0;
      resRe_q    <= '0;
      resIm_q    <= '0;
      err_q      <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            samp_q[cnt_q] <= s_data;
            cnt_q         <= cnt_q + 3'd1;
            // A short frame is zero-padded so the core never sees stale
            // samples from the previous frame.
            if (s_last && (cnt_q != 3'd7)) begin
              for (int i = 0; i < 8; i++) begin
                if (3'(i) > cnt_q) samp_q[i] <= '0;
              end
            end
            if (s_last || (cnt_q == 3'd7)) begin
              state_q  <= ST_SETTLE;
              settle_q <= '0;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= ST_CAPTURE;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        ST_CAPTURE: begin
          resRe_q <= core_xr;
          resIm_q <= core_xi;
          k_q     <= '0;
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fire) begin
            k_q <= k_q + 3'd1;
            if (k_q == 3'd7) begin
              frameCnt_q <= frameCnt_q + 16'd1;
              cnt_q      <= '0;
              state_q    <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign s_ready   = (state_q == ST_LOAD);
  assign m_valid   = (state_q == ST_DRAIN);
  assign m_re      = resRe_q[k_q];
  assign m_im      = resIm_q[k_q];
  assign m_idx     = k_q;
  assign m_last    = (state_q == ST_DRAIN) && (k_q == 3'd7);
  assign busy      = (state_q != ST_LOAD) || (cnt_q != 3'd0);
  assign err       = err_q;
  assign frame_cnt = frameCnt_q;
  assign core_a    = samp_q;

endmodule

// File: doc/fft8_ctrl.md
# fft8_ctrl

Frame sequencer for the combinational 8-point FFT core. Accepts real samples one per handshake, holds a complete 8-sample frame stable on the core inputs, and waits a programmable settle time for the core's deep combinational path. It then captures all sixteen result words and streams the eight complex bins out in natural order over a valid/ready interface. It sits between the sample source and the result consumer; the FFT core instance sits beside it and is wired to the `core_*` ports.

## Interface
Parameters:
- `DATA_W`, 32: sample and result word width.
- `SETTLE`, 2: cycles the frame is held on `core_a` before capture; legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `s_valid`  in  1: input sample valid.
- `s_ready`  out  1: block can accept a sample.
- `s_data`  in  DATA_W: real sample, two's complement.
- `s_last`  in  1: marks the final sample of a frame.
- `core_a`  out  8*DATA_W: held frame; sample i at `[DATA_W*i +: DATA_W]`.
- `core_xr`  in  8*DATA_W: core real outputs; bin k at `[DATA_W*k +: DATA_W]`.
- `core_xi`  in  8*DATA_W: core imaginary outputs; same packing.
- `m_valid`  out  1: output bin valid.
- `m_ready`  in  1: consumer accepts a bin.
- `m_re`, `m_im`  out  DATA_W: bin real and imaginary parts.
- `m_idx`  out  3: bin index k.
- `m_last`  out  1: high with bin 7.
- `busy`  out  1: high in any state other than LOAD, and also in LOAD once the sample count is nonzero.
- `err`  out  1: sticky frame-framing error.
- `err_clr`  in  1: synchronous clear of `err`.
- `frame_cnt`  out  16: count of completed frames; wraps at 65535→0.

## Operation
- Four states: LOAD, SETTLE, CAPTURE, DRAIN. Reset state is LOAD.
- **LOAD**
  - `s_ready`=1.
  - Each `s_valid&s_ready` writes `s_data` into sample register `cnt` (3-bit) and increments `cnt`.
  - The 8th accept (`cnt`=7) moves the block to SETTLE.
  - Early `s_last` (at `cnt`<7): the sample is stored, samples `cnt+1..7` are zero-filled in the same cycle, `err` is set, and the block moves to SETTLE.
  - Missing `s_last` on the 8th sample: `err` is set and the block proceeds normally.
- **SETTLE**
  - `s_ready`=0.
  - A settle counter runs from 0 to SETTLE-1, then the block moves to CAPTURE.
- **CAPTURE**
  - One cycle. All 16 `core_xr`/`core_xi` words are registered into the result bank at the end of the cycle.
  - The block then moves to DRAIN with `k`=0.
- **DRAIN**
  - `m_valid`=1. `m_re`/`m_im` = result bank[k]. `m_idx`=k. `m_last`=(k==7).
  - Each `m_valid&m_ready` increments `k`.
  - The handshake at k=7 increments `frame_cnt`, clears `cnt`, and returns the block to LOAD.
- `core_a` is driven directly from the sample registers. It is stable from the last accept through the end of CAPTURE. Sample registers are overwritten only in LOAD.
- `err`: set events have priority over `err_clr` in the same cycle.
- No arithmetic is performed on the data; words pass through bit-exact.

## Timing
- Reset values:
  - `s_ready`=1; `m_valid`=0; `m_re`=`m_im`=0; `m_idx`=0; `m_last`=0.
  - `busy`=0; `err`=0; `frame_cnt`=0; `core_a`=0.
  - All internal counters = 0.
- Latency: if the final sample is accepted in cycle T, then:
  - SETTLE occupies T+1..T+SETTLE.
  - CAPTURE occurs at T+SETTLE+1.
  - `m_valid` first rises at T+SETTLE+2.
- Throughput: with `s_valid` and `m_ready` held high, one frame takes 8+SETTLE+1+8 cycles. There is no overlap between loading and draining.
- DRAIN outputs are held stable while `m_valid&!m_ready`. The consumer may stall indefinitely.
- `s_ready` falls in the cycle after the final accept and rises in the cycle after the k=7 handshake.
- Assertion of `rst_n` in any state aborts immediately: the frame is discarded and `frame_cnt` is unchanged from the reset value, i.e. 0.

## Test plan
- Impulse: samples 1,0,0,0,0,0,0,0 with `s_last` on the 8th; core model attached; SETTLE=2.
  - Expect `m_valid` 4 cycles after the last accept.
  - Expect 8 bins with `m_re`=1, `m_im`=0, `m_idx` 0..7, `m_last` only on bin 7, and `frame_cnt`=1.
- Backpressure: DC input of eight 5s, `m_ready` toggled 1,0,0,1,...
  - Expect bin 0 = (40,0) and all other bins = (0,0).
  - Outputs are held during stalls and no bin is dropped or duplicated.
- Early `s_last` on the 3rd sample (values 2,3,4):
  - Expect `core_a` = 2,3,4,0,0,0,0,0, `err`=1, and a frame emitted.
  - `err_clr` then clears `err`.
- Missing `s_last` on the 8th sample:
  - Expect `err`=1 with normal output.
  - Asserting `err_clr` in the same cycle as a new error event leaves `err`=1.
- Reset during DRAIN at k=3:
  - Expect all outputs at reset values asynchronously, `s_ready`=1, and `frame_cnt`=0.
  - The next frame processes correctly.
- Throughput check: 3 back-to-back frames with SETTLE=1, source and sink always ready.
  - Expect exactly 18 cycles per frame and `frame_cnt`=3.
